// File: rtl/reg_bank_pkg.sv
// Address map, version field widths and LED register layout shared by the register bank.
// Constants and types only; no logic, no latency, no flow control.
package reg_bank_pkg;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 6;
    localparam int VER_FIELD_W = 8;

    localparam logic [ADDR_W-1:0] ADDR_VERSION    = 6'h00;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_STATUS = 6'h01;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK   = 6'h02;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_EDGE   = 6'h03;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_RAW    = 6'h04;
    localparam logic [ADDR_W-1:0] ADDR_LED_BASE   = 6'h10;

    localparam int LED_FIELD_W  = 8;
    localparam int LED_BLUE_LSB = 0;
    localparam int LED_GREEN_LSB = 8;
    localparam int LED_RED_LSB  = 16;
    localparam int LED_DUTY_LSB = 24;

    typedef struct packed {
        logic [LED_FIELD_W-1:0] duty;
        logic [LED_FIELD_W-1:0] red;
        logic [LED_FIELD_W-1:0] green;
        logic [LED_FIELD_W-1:0] blue;
    } led_t;

endpackage

// File: rtl/reg_bank_irq_if.sv
// Register access bus: address, write strobe/data, read-consume strobe and read data.
// Read data returns one cycle after the address; no backpressure, every strobe is accepted.
interface reg_bank_irq_if;
    import reg_bank_pkg::*;

    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic              data_in_valid;
    logic              register_read;
    logic [DATA_W-1:0] data_out;

    modport master (
        output address, data_in, data_in_valid, register_read,
        input  data_out
    );

    modport slave (
        input  address, data_in, data_in_valid, register_read,
        output data_out
    );

endinterface

// File: rtl/irq_ctrl.sv
// Interrupt status: edge/level set, W1C/clear-on-read clear (set wins), registered interrupt.
// Status updates on the sampling edge, interrupt one cycle later; no backpressure.
module irq_ctrl #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic [NUM_IRQ-1:0] edge_sel,
    input  logic [NUM_IRQ-1:0] mask,
    input  logic [NUM_IRQ-1:0] clr,
    output logic [NUM_IRQ-1:0] status,
    output logic               interrupt
);

    logic [NUM_IRQ-1:0] src_d_q, src_d_d;
    logic [NUM_IRQ-1:0] status_q, status_d;
    logic [NUM_IRQ-1:0] set_vec;
    logic               interrupt_q, interrupt_d;

    always_comb begin
        set_vec     = (edge_sel & irq_src & ~src_d_q) | (~edge_sel & irq_src);
        src_d_d     = irq_src;
        // OR-ing set after the clear mask makes a simultaneous set win.
        status_d    = (status_q & ~clr) | set_vec;
        interrupt_d = |(status_q & mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_d_q     <= '0;
            status_q    <= '0;
            interrupt_q <= 1'b0;
        end else begin
            src_d_q     <= src_d_d;
            status_q    <= status_d;
            interrupt_q <= interrupt_d;
        end
    end

    assign status    = status_q;
    assign interrupt = interrupt_q;

endmodule

// File: rtl/reg_bank_irq.sv
// Register bank: version, IRQ status/mask/edge/raw and LED RGB registers with registered readback.
// Read data one cycle after address; writes land on the strobe edge; no backpressure.
module reg_bank_irq
    import reg_bank_pkg::*;
#(
    parameter int                     NUM_LEDS           = 3,
    parameter int                     NUM_IRQ            = 8,
    parameter int                     CLEAR_ON_READ      = 1,
    parameter logic [VER_FIELD_W-1:0] FPGA_VERSION_TYPE  = "A",
    parameter logic [VER_FIELD_W-1:0] FPGA_VERSION_MAJOR = 8'd0,
    parameter logic [VER_FIELD_W-1:0] FPGA_VERSION_MINOR = 8'd0,
    parameter logic [VER_FIELD_W-1:0] FPGA_VERSION_DEBUG = 8'd0
) (
    input  logic                       clk,
    input  logic                       rst,
    reg_bank_irq_if.slave              bus,
    input  logic [NUM_IRQ-1:0]         irq_src,
    output logic                       interrupt,
    output logic [NUM_LEDS*DATA_W-1:0] led_rgb
);

    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] edge_q, edge_d;
    logic [NUM_IRQ-1:0] irq_clr;
    logic [NUM_IRQ-1:0] irq_status;
    led_t               led_q [NUM_LEDS];
    led_t               led_d [NUM_LEDS];
    logic [DATA_W-1:0]  data_out_q, data_out_d;

    always_comb begin
        mask_d  = mask_q;
        edge_d  = edge_q;
        irq_clr = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            led_d[i] = led_q[i];
        end

        if (bus.data_in_valid) begin
            case (bus.address)
                ADDR_IRQ_STATUS: irq_clr = bus.data_in[NUM_IRQ-1:0];
                ADDR_IRQ_MASK:   mask_d  = bus.data_in[NUM_IRQ-1:0];
                ADDR_IRQ_EDGE:   edge_d  = bus.data_in[NUM_IRQ-1:0];
                default:         ;
            endcase
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (bus.address == ADDR_LED_BASE + ADDR_W'(i)) begin
                    led_d[i] = bus.data_in;
                end
            end
        end

        if ((CLEAR_ON_READ != 0) && bus.register_read && (bus.address == ADDR_IRQ_STATUS)) begin
            irq_clr = '1;
        end

        // Unmapped addresses and bits above NUM_IRQ fall through as zero.
        data_out_d = '0;
        case (bus.address)
            ADDR_VERSION:    data_out_d = {FPGA_VERSION_TYPE, FPGA_VERSION_MAJOR,
                                           FPGA_VERSION_MINOR, FPGA_VERSION_DEBUG};
            ADDR_IRQ_STATUS: data_out_d[NUM_IRQ-1:0] = irq_status;
            ADDR_IRQ_MASK:   data_out_d[NUM_IRQ-1:0] = mask_q;
            ADDR_IRQ_EDGE:   data_out_d[NUM_IRQ-1:0] = edge_q;
            ADDR_IRQ_RAW:    data_out_d[NUM_IRQ-1:0] = irq_src;
            default:         ;
        endcase
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (bus.address == ADDR_LED_BASE + ADDR_W'(i)) begin
                data_out_d = led_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q     <= '0;
            edge_q     <= '0;
            data_out_q <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                led_q[i] <= '0;
            end
        end else begin
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            data_out_q <= data_out_d;
            for (int i = 0; i < NUM_LEDS; i++) begin
                led_q[i] <= led_d[i];
            end
        end
    end

    irq_ctrl #(
        .NUM_IRQ (NUM_IRQ)
    ) u_irq_ctrl (
        .clk       (clk),
        .rst       (rst),
        .irq_src   (irq_src),
        .edge_sel  (edge_q),
        .mask      (mask_q),
        .clr       (irq_clr),
        .status    (irq_status),
        .interrupt (interrupt)
    );

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_led_out
        assign led_rgb[g*DATA_W + LED_DUTY_LSB  +: LED_FIELD_W] = led_q[g].duty;
        assign led_rgb[g*DATA_W + LED_RED_LSB   +: LED_FIELD_W] = led_q[g].red;
        assign led_rgb[g*DATA_W + LED_GREEN_LSB +: LED_FIELD_W] = led_q[g].green;
        assign led_rgb[g*DATA_W + LED_BLUE_LSB  +: LED_FIELD_W] = led_q[g].blue;
    end

    assign bus.data_out = data_out_q;

endmodule

// File: doc/reg_bank_irq.md
REG_BANK_IRQ -- requirements
Module: reg_bank_irq

Interface
REQ-001 Parameter NUM_LEDS, default 3: number of LED RGB registers; legal range 1..8.
REQ-002 Parameter NUM_IRQ, default 8: number of interrupt sources; legal range 1..32.
REQ-003 Parameter CLEAR_ON_READ, default 1: 1 = a read of IRQ_STATUS also clears it; 0 = write-1-to-clear only.
REQ-004 Parameters FPGA_VERSION_TYPE/MAJOR/MINOR/DEBUG, default "A"/0/0/0: 8-bit version fields.
REQ-005 clk  in  1  single clock; all logic is on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 address  in  6  register select.
REQ-008 data_in  in  32  write data.
REQ-009 data_in_valid  in  1  one-cycle write strobe.
REQ-010 register_read  in  1  one-cycle read-consume strobe.
REQ-011 data_out  out  32  registered read data.
REQ-012 interrupt  out  1  registered, level-high interrupt request.
REQ-013 irq_src  in  NUM_IRQ  interrupt sources, synchronous to clk.
REQ-014 led_rgb  out  NUM_LEDS*32  LED i occupies bits [32i+31:32i] as {dutycycle, red, green, blue}.

Function
REQ-015 Address map: 0x00 VERSION (RO) {type,major,minor,debug}; 0x01 IRQ_STATUS (R/W1C); 0x02 IRQ_MASK (RW); 0x03 IRQ_EDGE (RW, 1=rising-edge source, 0=level source); 0x04 IRQ_RAW (RO, current irq_src); 0x10+i LED i (RW) for i<NUM_LEDS.
REQ-016 data_out SHALL reflect the register at the address sampled in cycle N at cycle N+1, every cycle, independent of register_read.
REQ-017 Unmapped addresses, including 0x10+i for i>=NUM_LEDS, SHALL read 0; writes to them, and to RO registers, SHALL be ignored.
REQ-018 Bits [31:NUM_IRQ] of IRQ_STATUS, IRQ_MASK, IRQ_EDGE and IRQ_RAW SHALL read 0 and ignore writes.
REQ-019 Writes take effect at the clock edge on which data_in_valid is high; a read of the same address in the next cycle returns the new value.
REQ-020 Edge detect: src_d <= irq_src each cycle; edge[k] = irq_src[k] & ~src_d[k].
REQ-021 Set condition per bit k: IRQ_EDGE[k] ? edge[k] : irq_src[k].
REQ-022 Clear condition per bit k: (write to 0x01 with data_in[k]=1) or (CLEAR_ON_READ=1 and register_read at 0x01).
REQ-023 Set and clear in the same cycle: set wins; the bit is 1 afterwards.
REQ-024 A level source still high after a clear re-sets its bit on the next cycle.
REQ-025 interrupt SHALL equal |(IRQ_STATUS & IRQ_MASK) registered: one cycle after status/mask changes.
REQ-026 Changing IRQ_EDGE SHALL NOT modify IRQ_STATUS.
REQ-027 Simultaneous data_in_valid and register_read at 0x01 SHALL apply both clear sources (OR).

Reset
REQ-028 With rst high at a clock edge: data_out, interrupt, led_rgb, IRQ_STATUS, IRQ_MASK, IRQ_EDGE, src_d SHALL become 0; strobes are ignored in that cycle.
REQ-029 Because src_d resets to 0, an edge source already high in the first cycle after reset SHALL set its status bit.
REQ-030 Reset mid-operation discards pending status without generating interrupt.

Structure
REQ-031 Package reg_bank_pkg SHALL hold the address constants, version field widths and the LED register field offsets.
REQ-032 Sub-module irq_ctrl SHALL hold src_d, edge detect, status set/clear and the interrupt register, parameterised by NUM_IRQ; reg_bank_irq holds the decode, LED/mask/edge registers and read mux.

Verification
REQ-033 After reset read 0x00 with version A.1.2.3 -> data_out 0x41010203 one cycle later; read 0x10..0x12 -> 0.
REQ-034 NUM_LEDS=3: write 0x12 = 0xFF102030 -> led_rgb[95:64]=0xFF102030; write 0x13 = 0x12345678 then read 0x13 -> 0.
REQ-035 IRQ_EDGE=0x01, IRQ_MASK=0x01, irq_src[0] high for 5 cycles -> STATUS=0x01 once, interrupt high 2 cycles after the rising edge; W1C 0x01 with source still high -> STATUS stays 0.
REQ-036 IRQ_EDGE=0x00, irq_src[1] held high, W1C 0x02 -> STATUS bit1 reads 1 again next cycle; drop source, W1C 0x02 -> STATUS=0, interrupt falls one cycle later.
REQ-037 CLEAR_ON_READ=1, edge on irq_src[2] in the same cycle as register_read at 0x01 -> STATUS bit2 = 1 afterwards.
REQ-038 NUM_IRQ=4: write 0x02 = 0xFFFFFFFF -> read 0x0000000F; assert rst with STATUS=0x0F -> STATUS, interrupt 0 next cycle.
